// File: rtl/buffer_pkg.sv
// Shared definitions for the cache-side write/fill buffer: default geometry,
// read-mode encoding and the occupancy-count width helper.
package buffer_pkg;

    localparam int BUF_WIDTH_DEF = 32;
    localparam int BUF_DEPTH_DEF = 32;

    typedef enum logic [0:0] {
        BUF_STD  = 1'b0,
        BUF_FWFT = 1'b1
    } buf_mode_e;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/buffer_ptr.sv
// Wrapping index counter for the buffer storage; wraps explicitly at DEPTH-1
// so non-power-of-two depths address only valid entries.
module buffer_ptr #(
    parameter int DEPTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_inc,
    input  logic                     i_clr,
    output logic [$clog2(DEPTH)-1:0] o_ptr
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] r_ptr;

    // Pointer register: clear has priority over increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PW'(1);
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/param_buffer.sv
// Parametrised synchronous FIFO between cache controller and memory interface,
// with optional first-word-fall-through, occupancy flags and sticky error flags.
module param_buffer
    import buffer_pkg::*;
#(
    parameter int WIDTH    = BUF_WIDTH_DEF,
    parameter int DEPTH    = BUF_DEPTH_DEF,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          EN,
    input  logic                          WR,
    input  logic                          RD,
    input  logic                          FLUSH,
    input  logic [WIDTH-1:0]              dataIn,
    output logic [WIDTH-1:0]              dataOut,
    output logic                          EMPTY,
    output logic                          FULL,
    output logic                          ALMOST_FULL,
    output logic                          ALMOST_EMPTY,
    output logic [count_width(DEPTH)-1:0] COUNT,
    output logic                          OVERFLOW,
    output logic                          UNDERFLOW
);

    localparam int CW = count_width(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    if (DEPTH < 2 || AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_bad_params
        $error("param_buffer: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_udf;
    logic [PW-1:0]    w_wr_ptr;
    logic [PW-1:0]    w_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_act;
    logic             w_flush;
    logic             w_rd_ok;
    logic             w_wr_ok;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);
    assign w_act   = EN & ~FLUSH;
    assign w_flush = EN & FLUSH;
    // A write into a full buffer is still accepted when a read frees a slot.
    assign w_rd_ok = w_act & RD & ~w_empty;
    assign w_wr_ok = w_act & WR & (~w_full | w_rd_ok);

    buffer_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .i_clk (Clk),
        .i_rst (Rst),
        .i_inc (w_wr_ok),
        .i_clr (w_flush),
        .o_ptr (w_wr_ptr)
    );

    buffer_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .i_clk (Clk),
        .i_rst (Rst),
        .i_inc (w_rd_ok),
        .i_clr (w_flush),
        .o_ptr (w_rd_ptr)
    );

    // Storage array; contents deliberately not reset.
    always_ff @(posedge Clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_ptr] <= dataIn;
        end
    end

    // Occupancy count.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_count <= '0;
        end else if (w_flush) begin
            r_count <= '0;
        end else begin
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags, frozen while EN is low.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (w_flush) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (w_act) begin
            r_ovf <= r_ovf | (WR & ~w_wr_ok);
            r_udf <= r_udf | (RD & ~w_rd_ok);
        end else begin
            r_ovf <= r_ovf;
            r_udf <= r_udf;
        end
    end

    if (FWFT == int'(BUF_FWFT)) begin : g_fwft
        logic [WIDTH-1:0] w_dout;

        // Head word presented combinationally; zero when nothing is stored.
        always_comb begin
            w_dout = '0;
            if (!w_empty) begin
                w_dout = r_mem[w_rd_ptr];
            end else begin
                w_dout = '0;
            end
        end

        assign dataOut = w_dout;
    end else begin : g_std
        logic [WIDTH-1:0] r_dout;

        // Registered read data, loaded only on an accepted read.
        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                r_dout <= '0;
            end else if (w_flush) begin
                r_dout <= '0;
            end else if (w_rd_ok) begin
                r_dout <= r_mem[w_rd_ptr];
            end else begin
                r_dout <= r_dout;
            end
        end

        assign dataOut = r_dout;
    end

    assign COUNT        = r_count;
    assign EMPTY        = w_empty;
    assign FULL         = w_full;
    assign ALMOST_FULL  = (r_count >= AF_C);
    assign ALMOST_EMPTY = (r_count <= AE_C);
    assign OVERFLOW     = r_ovf;
    assign UNDERFLOW    = r_udf;

endmodule

// File: tb/tb_param_buffer.sv
// Directed bench for param_buffer: default instance (32x32 standard), a
// 5-deep instance for pointer wrap and thresholds, and an FWFT instance.
module tb_param_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  [3];
    logic        wr  [3];
    logic        rd  [3];
    logic        fl  [3];
    logic [31:0] din [3];
    logic [31:0] dout[3];
    logic        empty[3];
    logic        full [3];
    logic        af   [3];
    logic        ae   [3];
    logic        ovf  [3];
    logic        udf  [3];
    logic [5:0]  cnt0;
    logic [2:0]  cnt1;
    logic [5:0]  cnt2;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    param_buffer u0 (
        .Clk(clk), .Rst(rst), .EN(en[0]), .WR(wr[0]), .RD(rd[0]), .FLUSH(fl[0]),
        .dataIn(din[0]), .dataOut(dout[0]), .EMPTY(empty[0]), .FULL(full[0]),
        .ALMOST_FULL(af[0]), .ALMOST_EMPTY(ae[0]), .COUNT(cnt0),
        .OVERFLOW(ovf[0]), .UNDERFLOW(udf[0])
    );

    param_buffer #(.DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u1 (
        .Clk(clk), .Rst(rst), .EN(en[1]), .WR(wr[1]), .RD(rd[1]), .FLUSH(fl[1]),
        .dataIn(din[1]), .dataOut(dout[1]), .EMPTY(empty[1]), .FULL(full[1]),
        .ALMOST_FULL(af[1]), .ALMOST_EMPTY(ae[1]), .COUNT(cnt1),
        .OVERFLOW(ovf[1]), .UNDERFLOW(udf[1])
    );

    param_buffer #(.FWFT(1)) u2 (
        .Clk(clk), .Rst(rst), .EN(en[2]), .WR(wr[2]), .RD(rd[2]), .FLUSH(fl[2]),
        .dataIn(din[2]), .dataOut(dout[2]), .EMPTY(empty[2]), .FULL(full[2]),
        .ALMOST_FULL(af[2]), .ALMOST_EMPTY(ae[2]), .COUNT(cnt2),
        .OVERFLOW(ovf[2]), .UNDERFLOW(udf[2])
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] din;
        logic [31:0] cnt;
        logic [31:0] dout;
        logic        af;
        logic        ae;
        logic        full;
        logic        empty;
    } vec_t;

    vec_t vt[23];

    function automatic vec_t mk(input int w, input int r, input int d, input int c,
                                input int o, input int a_f, input int a_e,
                                input int f, input int e);
        vec_t v;
        v.wr = w[0]; v.rd = r[0]; v.din = d; v.cnt = c; v.dout = o;
        v.af = a_f[0]; v.ae = a_e[0]; v.full = f[0]; v.empty = e[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus on instance k; outputs are stable 1 time unit after the edge.
    task automatic cyc(input int k, input logic e, input logic w, input logic r,
                       input logic f, input logic [31:0] d);
        en[k] = e; wr[k] = w; rd[k] = r; fl[k] = f; din[k] = d;
        @(posedge clk);
        #1;
        wr[k] = 1'b0; rd[k] = 1'b0; fl[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b1; wr[k] = 1'b0; rd[k] = 1'b0; fl[k] = 1'b0; din[k] = 32'd0;
        end
        vt[0]  = mk(1, 0, 10, 1, 0,  0, 1, 0, 0);
        vt[1]  = mk(1, 0, 11, 2, 0,  0, 0, 0, 0);
        vt[2]  = mk(1, 0, 12, 3, 0,  0, 0, 0, 0);
        vt[3]  = mk(1, 0, 13, 4, 0,  1, 0, 0, 0);
        vt[4]  = mk(0, 1, 0,  3, 10, 0, 0, 0, 0);
        vt[5]  = mk(1, 0, 14, 4, 10, 1, 0, 0, 0);
        vt[6]  = mk(1, 0, 15, 5, 10, 1, 0, 1, 0);
        vt[7]  = mk(0, 1, 0,  4, 11, 1, 0, 0, 0);
        vt[8]  = mk(1, 0, 16, 5, 11, 1, 0, 1, 0);
        vt[9]  = mk(0, 1, 0,  4, 12, 1, 0, 0, 0);
        vt[10] = mk(0, 1, 0,  3, 13, 0, 0, 0, 0);
        vt[11] = mk(1, 0, 17, 4, 13, 1, 0, 0, 0);
        vt[12] = mk(0, 1, 0,  3, 14, 0, 0, 0, 0);
        vt[13] = mk(0, 1, 0,  2, 15, 0, 0, 0, 0);
        vt[14] = mk(0, 1, 0,  1, 16, 0, 1, 0, 0);
        vt[15] = mk(1, 1, 18, 1, 17, 0, 1, 0, 0);
        vt[16] = mk(1, 0, 19, 2, 17, 0, 0, 0, 0);
        vt[17] = mk(0, 1, 0,  1, 18, 0, 1, 0, 0);
        vt[18] = mk(1, 0, 20, 2, 18, 0, 0, 0, 0);
        vt[19] = mk(1, 0, 21, 3, 18, 0, 0, 0, 0);
        vt[20] = mk(0, 1, 0,  2, 19, 0, 0, 0, 0);
        vt[21] = mk(0, 1, 0,  1, 20, 0, 1, 0, 0);
        vt[22] = mk(0, 1, 0,  0, 21, 0, 1, 0, 1);

        // Reset state
        @(posedge clk);
        #1;
        check("rst count", {26'd0, cnt0}, 32'd0);
        check("rst empty", {31'd0, empty[0]}, 32'd1);
        check("rst aempty", {31'd0, ae[0]}, 32'd1);
        check("rst full", {31'd0, full[0]}, 32'd0);
        check("rst afull", {31'd0, af[0]}, 32'd0);
        check("rst ovf", {31'd0, ovf[0]}, 32'd0);
        check("rst udf", {31'd0, udf[0]}, 32'd0);
        check("rst dout", dout[0], 32'd0);
        check("rst fwft dout", dout[2], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill the default buffer with 1..32
        for (int i = 1; i <= 32; i++) begin
            cyc(0, 1'b1, 1'b1, 1'b0, 1'b0, i);
            check($sformatf("fill%0d count", i), {26'd0, cnt0}, i);
            check($sformatf("fill%0d afull", i), {31'd0, af[0]}, (i >= 30) ? 32'd1 : 32'd0);
        end
        check("fill full", {31'd0, full[0]}, 32'd1);
        check("fill dout", dout[0], 32'd0);

        // Write while full is rejected; simultaneous RD/WR while full is accepted
        cyc(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd99);
        check("ovf flag", {31'd0, ovf[0]}, 32'd1);
        check("ovf count", {26'd0, cnt0}, 32'd32);
        cyc(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd77);
        check("full rw count", {26'd0, cnt0}, 32'd32);
        check("full rw dout", dout[0], 32'd1);

        // Drain: 2..32 then 77; 99 never appears
        for (int j = 0; j < 32; j++) begin
            cyc(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
            check($sformatf("drain%0d dout", j), dout[0], (j < 31) ? (j + 2) : 77);
        end
        check("drain empty", {31'd0, empty[0]}, 32'd1);
        check("drain ovf sticky", {31'd0, ovf[0]}, 32'd1);

        // Underflow, simultaneous RD/WR while empty, flush
        cyc(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        check("udf flag", {31'd0, udf[0]}, 32'd1);
        check("udf dout held", dout[0], 32'd77);
        cyc(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd5);
        check("empty rw count", {26'd0, cnt0}, 32'd1);
        check("empty rw udf", {31'd0, udf[0]}, 32'd1);
        check("empty rw dout", dout[0], 32'd77);
        cyc(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        check("read5 dout", dout[0], 32'd5);
        cyc(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd8);
        cyc(0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd9);
        check("flush count", {26'd0, cnt0}, 32'd0);
        check("flush empty", {31'd0, empty[0]}, 32'd1);
        check("flush ovf", {31'd0, ovf[0]}, 32'd0);
        check("flush udf", {31'd0, udf[0]}, 32'd0);
        check("flush dout", dout[0], 32'd0);

        // Table: 5-deep buffer across pointer wrap
        for (int i = 0; i < 23; i++) begin
            cyc(1, 1'b1, vt[i].wr, vt[i].rd, 1'b0, vt[i].din);
            check($sformatf("v%0d count", i), {29'd0, cnt1}, vt[i].cnt);
            check($sformatf("v%0d dout", i), dout[1], vt[i].dout);
            check($sformatf("v%0d afull", i), {31'd0, af[1]}, {31'd0, vt[i].af});
            check($sformatf("v%0d aempty", i), {31'd0, ae[1]}, {31'd0, vt[i].ae});
            check($sformatf("v%0d full", i), {31'd0, full[1]}, {31'd0, vt[i].full});
            check($sformatf("v%0d empty", i), {31'd0, empty[1]}, {31'd0, vt[i].empty});
        end

        // FWFT: head visible without RD, RD pops
        cyc(2, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5);
        check("fwft head", dout[2], 32'hA5);
        check("fwft count", {26'd0, cnt2}, 32'd1);
        cyc(2, 1'b1, 1'b1, 1'b0, 1'b0, 32'hB6);
        check("fwft head kept", dout[2], 32'hA5);
        cyc(2, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        check("fwft pop1", dout[2], 32'hB6);
        cyc(2, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        check("fwft pop2", dout[2], 32'd0);
        check("fwft empty", {31'd0, empty[2]}, 32'd1);

        // EN=0 freezes everything
        for (int i = 1; i <= 3; i++) cyc(0, 1'b1, 1'b1, 1'b0, 1'b0, i);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1'b0, i[0], ~i[0], (i == 2), 32'd55);
            check($sformatf("en0 c%0d count", i), {26'd0, cnt0}, 32'd3);
        end
        check("en0 dout", dout[0], 32'd0);
        check("en0 udf", {31'd0, udf[0]}, 32'd0);
        cyc(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        check("after en0 dout", dout[0], 32'd1);
        check("after en0 count", {26'd0, cnt0}, 32'd2);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check("async count", {26'd0, cnt0}, 32'd0);
        check("async empty", {31'd0, empty[0]}, 32'd1);
        check("async dout", dout[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd42);
        cyc(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        check("post rst dout", dout[0], 32'd42);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/param_buffer.md
Name: param_buffer

Overview:
Parametrised synchronous FIFO buffer; next generation of the 32x32 cache-side buffer, generalised in width and depth. Adds:
- a first-word-fall-through (FWFT) mode;
- an occupancy count;
- almost-full/almost-empty thresholds;
- sticky overflow/underflow flags;
- a synchronous flush.

It sits between the cache controller and the memory interface as a write/fill buffer.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 32, number of entries (>=2; not required to be a power of two)
FWFT, 0, 0 = standard mode (registered read data), 1 = first-word-fall-through
AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when count >= AF_LEVEL
AE_LEVEL, 2, ALMOST_EMPTY asserts when count <= AE_LEVEL

Ports:
Clk  in  1  clock, all state changes on rising edge
Rst  in  1  asynchronous, active-high reset
EN  in  1  global enable; when 0, RD/WR/FLUSH ignored, all state held
WR  in  1  write request
RD  in  1  read request
FLUSH  in  1  synchronous clear of contents and sticky flags (requires EN=1)
dataIn  in  WIDTH  write data
dataOut  out  WIDTH  read data
EMPTY  out  1  count == 0
FULL  out  1  count == DEPTH
ALMOST_FULL  out  1  count >= AF_LEVEL
ALMOST_EMPTY  out  1  count <= AE_LEVEL
COUNT  out  $clog2(DEPTH+1)  current occupancy
OVERFLOW  out  1  sticky: write attempted while FULL with no simultaneous accepted read
UNDERFLOW  out  1  sticky: read attempted while EMPTY

Behaviour:
- Reset (async, Rst=1):
  - pointers = 0, COUNT = 0, dataOut = 0;
  - EMPTY = 1, ALMOST_EMPTY = 1, FULL = 0, ALMOST_FULL = 0 (unless AF_LEVEL == 0);
  - OVERFLOW = UNDERFLOW = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all entries immediately.
- All flags are derived from the COUNT register, so they update in the same cycle as COUNT (one edge after the accepted op).
- Accept rules (EN=1, FLUSH=0):
  - wr_ok = WR & (!FULL | rd_ok);
  - rd_ok = RD & !EMPTY.
- Simultaneous RD & WR:
  - When FULL: both accepted, COUNT unchanged.
  - When EMPTY: write accepted, read rejected and UNDERFLOW set. No bypass: the written word becomes readable the next cycle.
- Rejected ops:
  - A rejected write sets OVERFLOW.
  - A rejected read sets UNDERFLOW.
  - Neither changes pointers or COUNT.
  - Flags stay set until Rst or FLUSH.
- Pointers:
  - wr_ptr / rd_ptr increment by 1 on an accepted op.
  - Explicit wrap from DEPTH-1 to 0; no reliance on power-of-two overflow.
- COUNT: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- FLUSH (EN=1):
  - pointers, COUNT and sticky flags cleared on the next edge; RD/WR in the same cycle are ignored;
  - dataOut cleared to 0 in standard mode.
- Standard mode (FWFT=0):
  - on rd_ok, dataOut <= mem[rd_ptr] at the edge, so the data is visible 1 cycle after RD;
  - otherwise dataOut holds its last value.
- FWFT mode (FWFT=1):
  - dataOut = mem[rd_ptr] combinationally whenever !EMPTY, and 0 when EMPTY;
  - RD acknowledges/pops the current head;
  - a word written into an empty buffer appears on dataOut 1 cycle after the write edge.
- EN=0: everything frozen, including sticky flag updates; outputs keep their values.
- Parameter check: elaboration error if DEPTH<2, AF_LEVEL>DEPTH, or AE_LEVEL>=DEPTH.

Decomposition:
- Package buffer_pkg holds:
  - function for the count width: clog2(DEPTH+1);
  - localparam defaults for WIDTH and DEPTH shared with the cache controller;
  - an enum buf_mode_e {BUF_STD, BUF_FWFT} used to document the FWFT parameter.
- One sub-module, buffer_ptr: a wrapping pointer counter with parameters DEPTH, inputs inc and clr, output ptr. It is instantiated twice (read and write).
- Storage is an inferred register array in param_buffer.

Test Plan:
1. Fill/drain, defaults, FWFT=0: write 1..32 -> FULL=1 and COUNT=32 after the 32nd edge. Then 32 reads -> dataOut = 1..32 in order, each 1 cycle after RD; EMPTY=1 after the last read.
2. Overflow and simultaneous ops when full: with FULL, WR=1 alone with dataIn=99 -> OVERFLOW=1, COUNT stays 32, 99 never read back. Then RD=1 & WR=1 with dataIn=77 -> COUNT stays 32, 77 is read last.
3. Underflow and simultaneous ops when empty: with EMPTY, RD=1 -> UNDERFLOW=1, dataOut unchanged. Then RD & WR with dataIn=5 -> COUNT=1, UNDERFLOW=1, next read returns 5. FLUSH=1 -> COUNT=0, both sticky flags clear.
4. Non-power-of-two depth: DEPTH=5, AF_LEVEL=4, AE_LEVEL=1, 12 write/read pairs of values 10..21 interleaved -> correct order across pointer wrap. ALMOST_FULL at COUNT=4, ALMOST_EMPTY at COUNT<=1.
5. FWFT=1: write 0xA5 into empty -> dataOut=0xA5 one cycle after the write edge without RD. RD pops it -> dataOut=0, EMPTY=1.
6. Reset/EN: load 3 words, EN=0 with RD/WR toggling -> COUNT stays 3. Assert Rst mid-cycle -> COUNT=0, EMPTY=1, dataOut=0 immediately, without waiting for a clock edge.
